// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the iterative multiply/divide unit
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave(input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 MULT/MULTU/DIV/DIVU over WIDTH+1 cycles, owns HI/LO, services MTHI/MTLO; ports clk, rst, m (start/op/a/b/flush in, busy/done/hi/lo out)
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  mdu_if.slave  m
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH-1:0]   mb, hi_q, lo_q, quo, rem, mag_a, mag_b;
  logic [WIDTH:0]     sum, diff;
  logic               div, sa, sb, done_q, go, sgn_a, sgn_b;
  always_comb begin
    go      = state == IDLE && m.start && !m.flush && !m.op[2];
    sgn_a   = !m.op[0] && m.a[WIDTH-1];
    sgn_b   = !m.op[0] && m.b[WIDTH-1];
    mag_a   = sgn_a ? -m.a : m.a;
    mag_b   = sgn_b ? -m.b : m.b;
    state_n = (state != IDLE && m.flush) ? IDLE :
              state == IDLE ? (go ? RUN : IDLE) :
              state == RUN  ? (cnt == CW'(WIDTH - 1) ? FIX : RUN) : IDLE;
    // multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mb : '0};
    diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
    step    = !div ? {sum, acc[WIDTH-1:1]} :
              diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod    = (sa ^ sb) ? -acc : acc;
    quo     = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mb     <= '0;
      div    <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= state == FIX && !m.flush;
      if (go) begin
        acc <= {{WIDTH{1'b0}}, mag_a};
        mb  <= mag_b;
        div <= m.op[1];
        sa  <= sgn_a;
        sb  <= sgn_b;
        cnt <= '0;
      end else if (state == RUN) begin
        acc <= step;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !m.flush)
        {hi_q, lo_q} <= div ? {rem, quo} : prod;
      else if (state == IDLE && m.start && !m.flush && m.op == 3'b100)
        hi_q <= m.a;
      else if (state == IDLE && m.start && !m.flush && m.op == 3'b101)
        lo_q <= m.a;
    end
  end
  assign m.busy = state != IDLE;
  assign m.done = done_q;
  assign m.hi   = hi_q;
  assign m.lo   = lo_q;
endmodule
